// File: rtl/writeback_ctrl_if.sv
// Writeback bus bundle: ALU result, load-result handshake, reservation port,
// register-bank write port and pending scoreboard.
interface writeback_ctrl_if;
   logic        AluValid;
   logic [4:0]  AluAddr;
   logic [63:0] AluData;
   logic        MemValid;
   logic [4:0]  MemAddr;
   logic [63:0] MemData;
   logic        MemReady;
   logic        Reserve;
   logic [4:0]  ReserveAddr;
   logic        w;
   logic [4:0]  AddrC;
   logic [63:0] DataC;
   logic [31:0] Pending;

   modport master (
      output AluValid, AluAddr, AluData, MemValid, MemAddr, MemData,
             Reserve, ReserveAddr,
      input  MemReady, w, AddrC, DataC, Pending
   );

   modport slave (
      input  AluValid, AluAddr, AluData, MemValid, MemAddr, MemData,
             Reserve, ReserveAddr,
      output MemReady, w, AddrC, DataC, Pending
   );
endinterface

// File: rtl/writeback_ctrl.sv
// Register-bank writeback arbiter: ALU results win over a small load FIFO;
// the chosen result is registered onto the write port and clears its pending bit.
module writeback_ctrl #(
   parameter int DEPTH = 2
) (
   input logic           Clk,
   input logic           Reset_n,
   writeback_ctrl_if.slave wb
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [4:0]    fifo_addr_q [DEPTH];
   logic [63:0]   fifo_data_q [DEPTH];
   logic          w_q, w_d;
   logic [4:0]    addr_q, addr_d;
   logic [63:0]   data_q, data_d;
   logic [31:0]   pending_q, pending_d;

   logic          push, pop, fifo_ne, sel_vld;
   logic [4:0]    sel_addr;
   logic [63:0]   sel_data;
   logic [31:0]   clr_mask, set_mask;

   assign wb.MemReady = (count_q < CW'(DEPTH));
   assign wb.w        = w_q;
   assign wb.AddrC    = addr_q;
   assign wb.DataC    = data_q;
   assign wb.Pending  = pending_q;

   always_comb begin
      fifo_ne  = (count_q != '0);
      push     = wb.MemValid && wb.MemReady;
      pop      = !wb.AluValid && fifo_ne;
      sel_vld  = wb.AluValid || fifo_ne;
      sel_addr = wb.AluValid ? wb.AluAddr : fifo_addr_q[rd_ptr_q];
      sel_data = wb.AluValid ? wb.AluData : fifo_data_q[rd_ptr_q];

      // Power-of-two depth: pointers wrap by plain overflow
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      // r31 is a sink: consumed but never written
      w_d    = sel_vld && (sel_addr != 5'd31);
      addr_d = w_d ? sel_addr : addr_q;
      data_d = w_d ? sel_data : data_q;

      clr_mask  = sel_vld ? (32'd1 << sel_addr) : 32'd0;
      set_mask  = (wb.Reserve && wb.ReserveAddr != 5'd31) ? (32'd1 << wb.ReserveAddr) : 32'd0;
      pending_d = ((pending_q & ~clr_mask) | set_mask) & 32'h7FFF_FFFF;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         w_q       <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         pending_q <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         w_q       <= w_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         pending_q <= pending_d;
      end
   end

   // Payload storage needs no reset; count gates every read
   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= wb.MemAddr;
         fifo_data_q[wr_ptr_q] <= wb.MemData;
      end
   end
endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl: directed vector table, reset/full-FIFO sequences,
// and randomized traffic against a queue-based reference model.
module tb_writeback_ctrl;
   localparam int DEPTH = 2;

   logic Clk, Reset_n;
   int   errors = 0;
   int   checks = 0;

   writeback_ctrl_if wb_if ();
   writeback_ctrl #(.DEPTH(DEPTH)) dut (.Clk(Clk), .Reset_n(Reset_n), .wb(wb_if));

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      logic [4:0]  a;
      logic [63:0] d;
   } ent_t;

   typedef struct {
      logic av; logic [4:0] aa; logic [63:0] ad;
      logic mv; logic [4:0] ma; logic [63:0] md;
      logic rv; logic [4:0] ra;
      logic ew; logic [4:0] ea; logic [63:0] ed; logic [31:0] ep; logic er;
   } vec_t;

   // Reference model: FIFO as a queue, scoreboard as a bit vector
   ent_t        fq[$];
   logic [31:0] m_pend;
   logic        m_w;
   logic [4:0]  m_a;
   logic [63:0] m_d;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      m_pend = '0; m_w = 1'b0; m_a = '0; m_d = '0;
   endtask

   // Called at posedge+1; drives one cycle, advances the model, checks after the edge
   task automatic step(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [63:0] md,
                       input logic rv, input logic [4:0] ra);
      logic        have;
      ent_t        s;
      wb_if.AluValid = av; wb_if.AluAddr = aa; wb_if.AluData = ad;
      wb_if.MemValid = mv; wb_if.MemAddr = ma; wb_if.MemData = md;
      wb_if.Reserve  = rv; wb_if.ReserveAddr = ra;
      #1;
      chk("mem_ready", 64'(wb_if.MemReady), 64'(fq.size() < DEPTH));
      have = 1'b0;
      s    = '{a: 5'd0, d: 64'd0};
      if (av) begin
         have = 1'b1; s = '{a: aa, d: ad};
      end else if (fq.size() > 0) begin
         have = 1'b1; s = fq.pop_front();
      end
      if (mv && (fq.size() + (have && !av ? 1 : 0)) < DEPTH) fq.push_back('{a: ma, d: md});
      if (have) m_pend[s.a] = 1'b0;
      if (rv && ra != 5'd31) m_pend[ra] = 1'b1;
      m_w = have && s.a != 5'd31;
      if (m_w) begin m_a = s.a; m_d = s.d; end
      @(posedge Clk); #1;
      chk("w", 64'(wb_if.w), 64'(m_w));
      chk("addr_c", 64'(wb_if.AddrC), 64'(m_a));
      chk("data_c", wb_if.DataC, m_d);
      chk("pending", 64'(wb_if.Pending), 64'(m_pend));
   endtask

   function automatic vec_t mk(input int av, input int aa, input logic [63:0] ad,
                               input int mv, input int ma, input logic [63:0] md,
                               input int rv, input int ra,
                               input int ew, input int ea, input logic [63:0] ed,
                               input logic [31:0] ep, input int er);
      vec_t v;
      v.av = av[0]; v.aa = aa[4:0]; v.ad = ad;
      v.mv = mv[0]; v.ma = ma[4:0]; v.md = md;
      v.rv = rv[0]; v.ra = ra[4:0];
      v.ew = ew[0]; v.ea = ea[4:0]; v.ed = ed; v.ep = ep; v.er = er[0];
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      logic        p_v;
      logic [4:0]  p_a;
      logic [63:0] p_d;
      logic        acc;

      // Directed table: reservation/clear, ALU-vs-FIFO, r31 sink, set-wins
      tbl.push_back(mk(0,0,0,      0,0,0,       1,5, 0,0,0,       32'h20,1));
      tbl.push_back(mk(0,0,0,      0,0,0,       0,0, 0,0,0,       32'h20,1));
      tbl.push_back(mk(1,5,64'hA,  0,0,0,       0,0, 1,5,64'hA,   32'h0,1));
      tbl.push_back(mk(0,0,0,      0,0,0,       0,0, 0,5,64'hA,   32'h0,1));
      tbl.push_back(mk(1,10,100,   1,1,64'h11,  0,0, 1,10,100,    32'h0,1));
      tbl.push_back(mk(1,11,101,   1,2,64'h22,  0,0, 1,11,101,    32'h0,0));
      tbl.push_back(mk(1,12,102,   1,3,64'h33,  0,0, 1,12,102,    32'h0,0));
      tbl.push_back(mk(0,0,0,      1,3,64'h33,  0,0, 1,1,64'h11,  32'h0,1));
      tbl.push_back(mk(0,0,0,      1,3,64'h33,  0,0, 1,2,64'h22,  32'h0,1));
      tbl.push_back(mk(0,0,0,      0,0,0,       0,0, 1,3,64'h33,  32'h0,1));
      tbl.push_back(mk(0,0,0,      0,0,0,       0,0, 0,3,64'h33,  32'h0,1));
      tbl.push_back(mk(1,31,64'h66,1,31,64'h55, 0,0, 0,3,64'h33,  32'h0,1));
      tbl.push_back(mk(0,0,0,      0,0,0,       0,0, 0,3,64'h33,  32'h0,1));
      tbl.push_back(mk(0,0,0,      0,0,0,       0,0, 0,3,64'h33,  32'h0,1));
      tbl.push_back(mk(0,0,0,      0,0,0,       1,7, 0,3,64'h33,  32'h80,1));
      tbl.push_back(mk(1,7,64'h77, 0,0,0,       1,7, 1,7,64'h77,  32'h80,1));
      tbl.push_back(mk(1,7,64'h78, 0,0,0,       0,0, 1,7,64'h78,  32'h0,1));

      wb_if.AluValid = 1'b0; wb_if.AluAddr = '0; wb_if.AluData = '0;
      wb_if.MemValid = 1'b0; wb_if.MemAddr = '0; wb_if.MemData = '0;
      wb_if.Reserve  = 1'b0; wb_if.ReserveAddr = '0;
      Reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_w", 64'(wb_if.w), 64'd0);
      chk("rst_addr", 64'(wb_if.AddrC), 64'd0);
      chk("rst_data", wb_if.DataC, 64'd0);
      chk("rst_pending", 64'(wb_if.Pending), 64'd0);
      chk("rst_ready", 64'(wb_if.MemReady), 64'd1);
      Reset_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].rv, tbl[i].ra);
         chk($sformatf("tbl%0d_w", i), 64'(wb_if.w), 64'(tbl[i].ew));
         chk($sformatf("tbl%0d_addr", i), 64'(wb_if.AddrC), 64'(tbl[i].ea));
         chk($sformatf("tbl%0d_data", i), wb_if.DataC, tbl[i].ed);
         chk($sformatf("tbl%0d_pend", i), 64'(wb_if.Pending), 64'(tbl[i].ep));
         chk($sformatf("tbl%0d_ready", i), 64'(wb_if.MemReady), 64'(tbl[i].er));
      end

      // Reset mid-operation with two loads queued and a reservation live
      step(1'b1, 5'd10, 64'd1, 1'b1, 5'd20, 64'h20, 1'b1, 5'd20);
      step(1'b1, 5'd11, 64'd2, 1'b1, 5'd21, 64'h21, 1'b0, 5'd0);
      #2 Reset_n = 1'b0;
      #1;
      chk("midrst_w", 64'(wb_if.w), 64'd0);
      chk("midrst_addr", 64'(wb_if.AddrC), 64'd0);
      chk("midrst_data", wb_if.DataC, 64'd0);
      chk("midrst_pending", 64'(wb_if.Pending), 64'd0);
      chk("midrst_ready", 64'(wb_if.MemReady), 64'd1);
      model_reset();
      @(posedge Clk); #1;
      chk("inrst_w", 64'(wb_if.w), 64'd0);
      Reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
         chk("no_write_after_rst", 64'(wb_if.w), 64'd0);
      end

      // Full FIFO, then ALU idles while the producer keeps offering
      step(1'b1, 5'd1, 64'd1, 1'b1, 5'd8, 64'h108, 1'b0, 5'd0);
      step(1'b1, 5'd2, 64'd2, 1'b1, 5'd9, 64'h109, 1'b0, 5'd0);
      p_a = 5'd10;
      for (int i = 0; i < 8; i++) begin
         acc = (fq.size() < DEPTH) && (p_a < 5'd14);
         step(1'b0, 5'd0, 64'd0, p_a < 5'd14, p_a, 64'h100 + 64'(p_a), 1'b0, 5'd0);
         if (acc) p_a = p_a + 5'd1;
      end
      chk("full_all_pushed", 64'(p_a), 64'd14);

      // Randomized traffic with a producer that holds unaccepted offers
      p_v = 1'b0; p_a = '0; p_d = '0;
      for (int i = 0; i < 600; i++) begin
         logic        av, rv;
         logic [4:0]  aa, ra;
         logic [63:0] ad;
         av = ($urandom_range(0, 2) == 0);
         aa = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         ad = {$urandom, $urandom};
         rv = ($urandom_range(0, 4) < 2);
         ra = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         if (!p_v && $urandom_range(0, 1) == 1) begin
            p_v = 1'b1;
            p_a = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            p_d = {$urandom, $urandom};
         end
         acc = p_v && (fq.size() < DEPTH);
         step(av, aa, ad, p_v, p_a, p_d, rv, ra);
         if (acc) p_v = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
